// File: rtl/bcd_operand_sequencer_if.sv
// rtl/bcd_operand_sequencer_if.sv - key/result/operand signal bundle for the BCD operand sequencer
interface bcd_operand_sequencer_if;
    logic       key_valid;
    logic [3:0] key_code;
    logic [3:0] res_10;
    logic [3:0] res_1;
    logic       res_flag;
    logic [3:0] op_a_10;
    logic [3:0] op_a_1;
    logic [3:0] op_b_10;
    logic [3:0] op_b_1;
    logic       operator;
    logic       operands_valid;
    logic [3:0] result_10;
    logic [3:0] result_1;
    logic       result_err;
    logic       key_err;
    logic [1:0] state;

    // master: keypad plus arithmetic stage; slave: the sequencer
    modport master (
        output key_valid, key_code, res_10, res_1, res_flag,
        input  op_a_10, op_a_1, op_b_10, op_b_1, operator, operands_valid,
        input  result_10, result_1, result_err, key_err, state
    );

    modport slave (
        input  key_valid, key_code, res_10, res_1, res_flag,
        output op_a_10, op_a_1, op_b_10, op_b_1, operator, operands_valid,
        output result_10, result_1, result_err, key_err, state
    );
endinterface

// File: rtl/bcd_operand_sequencer.sv
// rtl/bcd_operand_sequencer.sv - keypad-driven two-digit BCD operand entry and result latch
module bcd_operand_sequencer (
    input  logic                      clk,
    input  logic                      reset,
    bcd_operand_sequencer_if.slave    bus
);
    typedef enum logic [1:0] {
        ST_ENTER_A = 2'b00,
        ST_ENTER_B = 2'b01,
        ST_WAIT    = 2'b10,
        ST_DONE    = 2'b11
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] op_a_10_q, op_a_10_d;
    logic [3:0] op_a_1_q, op_a_1_d;
    logic [3:0] op_b_10_q, op_b_10_d;
    logic [3:0] op_b_1_q, op_b_1_d;
    logic [1:0] a_cnt_q, a_cnt_d;
    logic [1:0] b_cnt_q, b_cnt_d;
    logic       operator_q, operator_d;
    logic [3:0] result_10_q, result_10_d;
    logic [3:0] result_1_q, result_1_d;
    logic       result_err_q, result_err_d;
    logic       key_err_q, key_err_d;

    logic is_digit, is_op, is_eq, is_clr;

    always_comb begin
        is_digit = bus.key_valid && (bus.key_code <= 4'd9);
        is_op    = bus.key_valid && ((bus.key_code == 4'hA) || (bus.key_code == 4'hB));
        is_eq    = bus.key_valid && (bus.key_code == 4'hC);
        is_clr   = bus.key_valid && (bus.key_code == 4'hD);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_ENTER_A;
            op_a_10_q    <= 4'd0;
            op_a_1_q     <= 4'd0;
            op_b_10_q    <= 4'd0;
            op_b_1_q     <= 4'd0;
            a_cnt_q      <= 2'd0;
            b_cnt_q      <= 2'd0;
            operator_q   <= 1'b0;
            result_10_q  <= 4'd0;
            result_1_q   <= 4'd0;
            result_err_q <= 1'b0;
            key_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            op_a_10_q    <= op_a_10_d;
            op_a_1_q     <= op_a_1_d;
            op_b_10_q    <= op_b_10_d;
            op_b_1_q     <= op_b_1_d;
            a_cnt_q      <= a_cnt_d;
            b_cnt_q      <= b_cnt_d;
            operator_q   <= operator_d;
            result_10_q  <= result_10_d;
            result_1_q   <= result_1_d;
            result_err_q <= result_err_d;
            key_err_q    <= key_err_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        op_a_10_d    = op_a_10_q;
        op_a_1_d     = op_a_1_q;
        op_b_10_d    = op_b_10_q;
        op_b_1_d     = op_b_1_q;
        a_cnt_d      = a_cnt_q;
        b_cnt_d      = b_cnt_q;
        operator_d   = operator_q;
        result_10_d  = result_10_q;
        result_1_d   = result_1_q;
        result_err_d = result_err_q;
        key_err_d    = 1'b0;

        case (state_q)
            ST_ENTER_A: begin
                if (is_digit) begin
                    if (a_cnt_q < 2'd2) begin
                        op_a_10_d = op_a_1_q;
                        op_a_1_d  = bus.key_code;
                        a_cnt_d   = a_cnt_q + 2'd1;
                    end else begin
                        key_err_d = 1'b1;
                    end
                end else if (is_op) begin
                    operator_d = bus.key_code[0];
                    op_b_10_d  = 4'd0;
                    op_b_1_d   = 4'd0;
                    b_cnt_d    = 2'd0;
                    state_d    = ST_ENTER_B;
                end else if (bus.key_valid && !is_clr) begin
                    key_err_d = 1'b1;
                end
            end
            ST_ENTER_B: begin
                if (is_digit) begin
                    if (b_cnt_q < 2'd2) begin
                        op_b_10_d = op_b_1_q;
                        op_b_1_d  = bus.key_code;
                        b_cnt_d   = b_cnt_q + 2'd1;
                    end else begin
                        key_err_d = 1'b1;
                    end
                end else if (is_op) begin
                    operator_d = bus.key_code[0];
                end else if (is_eq) begin
                    state_d = ST_WAIT;
                end else if (bus.key_valid && !is_clr) begin
                    key_err_d = 1'b1;
                end
            end
            ST_WAIT: begin
                // the arithmetic stage has had one full cycle to settle on the held operands
                result_10_d  = bus.res_10;
                result_1_d   = bus.res_1;
                result_err_d = bus.res_flag;
                state_d      = ST_DONE;
                if (bus.key_valid && !is_clr) begin
                    key_err_d = 1'b1;
                end
            end
            ST_DONE: begin
                if (is_digit) begin
                    op_a_10_d  = 4'd0;
                    op_a_1_d   = bus.key_code;
                    a_cnt_d    = 2'd1;
                    op_b_10_d  = 4'd0;
                    op_b_1_d   = 4'd0;
                    b_cnt_d    = 2'd0;
                    operator_d = 1'b0;
                    state_d    = ST_ENTER_A;
                end else if (is_op) begin
                    if (result_err_q) begin
                        key_err_d = 1'b1;
                    end else begin
                        op_a_10_d  = result_10_q;
                        op_a_1_d   = result_1_q;
                        a_cnt_d    = 2'd2;
                        op_b_10_d  = 4'd0;
                        op_b_1_d   = 4'd0;
                        b_cnt_d    = 2'd0;
                        operator_d = bus.key_code[0];
                        state_d    = ST_ENTER_B;
                    end
                end else if (bus.key_valid && !is_clr) begin
                    key_err_d = 1'b1;
                end
            end
            default: state_d = ST_ENTER_A;
        endcase

        // clear overrides everything, including a pending WAIT capture
        if (is_clr) begin
            state_d      = ST_ENTER_A;
            op_a_10_d    = 4'd0;
            op_a_1_d     = 4'd0;
            op_b_10_d    = 4'd0;
            op_b_1_d     = 4'd0;
            a_cnt_d      = 2'd0;
            b_cnt_d      = 2'd0;
            operator_d   = 1'b0;
            result_10_d  = 4'd0;
            result_1_d   = 4'd0;
            result_err_d = 1'b0;
            key_err_d    = 1'b0;
        end
    end

    assign bus.op_a_10        = op_a_10_q;
    assign bus.op_a_1         = op_a_1_q;
    assign bus.op_b_10        = op_b_10_q;
    assign bus.op_b_1         = op_b_1_q;
    assign bus.operator       = operator_q;
    assign bus.operands_valid = state_q[1];
    assign bus.result_10      = result_10_q;
    assign bus.result_1       = result_1_q;
    assign bus.result_err     = result_err_q;
    assign bus.key_err        = key_err_q;
    assign bus.state          = state_q;
endmodule

// File: tb/tb_bcd_operand_sequencer.sv
// tb/tb_bcd_operand_sequencer.sv - directed self-checking bench for bcd_operand_sequencer
module tb_bcd_operand_sequencer;
    logic clk;
    logic reset;
    int   tests;
    int   fails;

    bcd_operand_sequencer_if bus();

    bcd_operand_sequencer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic press(input logic [3:0] code);
        @(negedge clk);
        bus.key_valid = 1'b1;
        bus.key_code  = code;
        @(negedge clk);
        bus.key_valid = 1'b0;
    endtask

    function automatic logic [7:0] op_a();
        return {bus.op_a_10, bus.op_a_1};
    endfunction

    function automatic logic [7:0] op_b();
        return {bus.op_b_10, bus.op_b_1};
    endfunction

    function automatic logic [7:0] res();
        return {bus.result_10, bus.result_1};
    endfunction

    initial begin
        tests = 0;
        fails = 0;
        bus.key_valid = 1'b0;
        bus.key_code  = 4'd0;
        bus.res_10    = 4'd0;
        bus.res_1     = 4'd0;
        bus.res_flag  = 1'b0;

        // reset wins over a simultaneous key
        reset = 1'b1;
        bus.key_valid = 1'b1;
        bus.key_code  = 4'd9;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        bus.key_valid = 1'b0;
        chk("rst_state", bus.state, 2'b00);
        chk("rst_op_a", op_a(), 8'h00);
        chk("rst_op_b", op_b(), 8'h00);
        chk("rst_result", res(), 8'h00);
        chk("rst_flags", {bus.operator, bus.operands_valid, bus.result_err, bus.key_err}, 4'b0000);

        // 42 + 17 with modelled result 59
        bus.res_10 = 4'd5; bus.res_1 = 4'd9; bus.res_flag = 1'b0;
        press(4'd4);
        chk("a_first_digit", op_a(), 8'h04);
        press(4'd2);
        chk("a_second_digit", op_a(), 8'h42);
        press(4'hA);
        chk("add_state", bus.state, 2'b01);
        chk("add_operator", bus.operator, 1'b0);
        press(4'd1);
        press(4'd7);
        chk("b_digits", op_b(), 8'h17);
        press(4'hC);
        chk("wait_state", bus.state, 2'b10);
        chk("wait_valid", bus.operands_valid, 1'b1);
        @(negedge clk);
        chk("done_state", bus.state, 2'b11);
        chk("done_result", res(), 8'h59);
        chk("done_flags", {bus.result_err, bus.operator, bus.operands_valid}, 3'b001);

        // 05 - 12 flagged underflow, then operator is refused
        bus.res_10 = 4'd9; bus.res_1 = 4'd3; bus.res_flag = 1'b1;
        press(4'd0);
        chk("new_entry_state", bus.state, 2'b00);
        chk("new_entry_op_a", op_a(), 8'h00);
        press(4'd5);
        chk("new_entry_op_a2", op_a(), 8'h05);
        press(4'hB);
        chk("sub_operator", bus.operator, 1'b1);
        press(4'd1);
        press(4'd2);
        press(4'hC);
        @(negedge clk);
        chk("flag_result", {bus.result_err, res()}, 9'h193);
        press(4'hA);
        chk("err_chain_pulse", {bus.key_err, bus.state}, 3'b111);
        @(negedge clk);
        chk("err_chain_clear", {bus.key_err, bus.state}, 3'b011);

        // third digit saturates
        press(4'd1);
        press(4'd2);
        chk("sat_two_digits", {bus.key_err, op_a()}, 9'h012);
        press(4'd3);
        chk("sat_third_digit", {bus.key_err, op_a()}, 9'h112);
        @(negedge clk);
        chk("sat_pulse_end", bus.key_err, 1'b0);
        press(4'hC);
        chk("eq_in_enter_a", {bus.key_err, bus.state}, 3'b100);

        // produce result 30, then chain with subtract
        bus.res_10 = 4'd3; bus.res_1 = 4'd0; bus.res_flag = 1'b0;
        press(4'hA);
        press(4'd1);
        press(4'd8);
        press(4'hC);
        @(negedge clk);
        chk("result_30", {bus.result_err, res()}, 9'h030);
        press(4'hB);
        chk("chain_op_a", op_a(), 8'h30);
        chk("chain_op_b", op_b(), 8'h00);
        chk("chain_state_op", {bus.operator, bus.state}, 3'b101);
        press(4'd7);
        chk("chain_b_digit", op_b(), 8'h07);
        press(4'hA);
        chk("op_replace", {bus.operator, bus.state, op_a(), op_b()}, 19'h0_30_07 | (19'd1 << 16));

        // illegal code in ENTER_B
        press(4'hE);
        chk("ill_b", {bus.key_err, bus.operator, bus.state, op_a(), op_b()}, {1'b1, 1'b0, 2'b01, 8'h30, 8'h07});

        // illegal code arriving during WAIT: flagged, capture still happens
        bus.res_10 = 4'd5; bus.res_1 = 4'd5;
        @(negedge clk);
        bus.key_valid = 1'b1;
        bus.key_code  = 4'hC;
        @(negedge clk);
        bus.key_code  = 4'hE;
        @(negedge clk);
        bus.key_valid = 1'b0;
        chk("ill_wait", {bus.key_err, bus.state, res()}, {1'b1, 2'b11, 8'h55});
        press(4'hE);
        chk("ill_done", {bus.key_err, bus.state, res(), op_a()}, {1'b1, 2'b11, 8'h55, 8'h30});
        press(4'hC);
        chk("eq_in_done", {bus.key_err, bus.state}, 3'b111);

        // illegal in ENTER_A, then clear mid ENTER_B
        press(4'd4);
        press(4'hF);
        chk("ill_a", {bus.key_err, bus.state, op_a()}, {1'b1, 2'b00, 8'h04});
        press(4'hA);
        press(4'd4);
        chk("pre_clear_b", op_b(), 8'h04);
        press(4'hD);
        chk("clear_all", {bus.key_err, bus.state, bus.operator, bus.operands_valid, bus.result_err, op_a(), op_b(), res()},
            29'h0);

        // reset mid-WAIT: no capture
        bus.res_10 = 4'd7; bus.res_1 = 4'd7;
        press(4'hA);
        press(4'hC);
        chk("pre_rst_wait", bus.state, 2'b10);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("rst_mid_wait", {bus.state, res(), bus.result_err}, 11'h0);

        // reset with simultaneous digit
        @(negedge clk);
        reset = 1'b1;
        bus.key_valid = 1'b1;
        bus.key_code  = 4'd9;
        @(negedge clk);
        reset = 1'b0;
        bus.key_valid = 1'b0;
        chk("rst_with_key", {bus.state, op_a()}, 10'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
